// File: rtl/cp0_pkg.sv
// Shared types and constants for the CP0 exception sequencer.
// Related macro: CP0_EXT_IRQ_EN (external interrupt entry, see cp0_exc_ctrl).
package cp0_pkg;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    FLUSH  = 2'd1,
    KERNEL = 2'd2
  } state_t;

  // Cause codes
  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_OVF  = 3'd1;
  localparam logic [2:0] C_PRIV = 3'd2;
  localparam logic [2:0] C_ILL  = 3'd3;
  localparam logic [2:0] C_IRQ  = 3'd4;

  // CP0 register numbers
  localparam logic [4:0] C0_STATUS = 5'd12;
  localparam logic [4:0] C0_CAUSE  = 5'd13;
  localparam logic [4:0] C0_EPC    = 5'd14;

  // Architectural view of Cause: bit31 = double fault, [4:2] = code.
  function automatic logic [31:0] pack_cause(input logic dbl, input logic [2:0] code);
    return {dbl, 26'd0, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// Status/Cause/EPC storage, write arbitration and mfc0 read mux.
// Hardware exception updates take priority over software writes; a return
// clears the double-fault flag, and a software write in the same cycle still lands.
// Related macro: CP0_EXT_IRQ_EN (no direct effect here).
module cp0_regs
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        kernel_mode,
  input  logic        hw_entry,
  input  logic        hw_dbl,
  input  logic [2:0]  hw_code,
  input  logic [31:0] hw_pc,
  input  logic        hw_ret,
  input  logic        sw_we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        ie
);

  logic [31:0] epc_r;
  logic [2:0]  code_r;
  logic        dbl_r;
  logic        ie_r;

  // Register update: reset, hardware exception, then return/software write.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_r  <= 32'd0;
      code_r <= 3'd0;
      dbl_r  <= 1'b0;
      ie_r   <= 1'b1;
    end else if (hw_entry) begin
      code_r <= hw_code;
      if (hw_dbl) begin
        dbl_r <= 1'b1;
      end else begin
        dbl_r <= 1'b0;
        epc_r <= hw_pc;
      end
    end else begin
      if (hw_ret) begin
        dbl_r <= 1'b0;
      end
      if (sw_we) begin
        case (waddr)
          C0_STATUS: ie_r <= wdata[1];
          C0_CAUSE: begin
            code_r <= wdata[4:2];
            dbl_r  <= wdata[31];
          end
          C0_EPC:  epc_r <= wdata;
          default: ;
        endcase
      end
    end
  end

  // Combinational read mux for mfc0; unmapped numbers read as zero.
  always_comb begin
    rdata = 32'd0;
    case (raddr)
      C0_STATUS: rdata = {30'd0, ie_r, kernel_mode};
      C0_CAUSE:  rdata = pack_cause(dbl_r, code_r);
      C0_EPC:    rdata = epc_r;
      default:   rdata = 32'd0;
    endcase
  end

  assign epc = epc_r;
  assign ie  = ie_r;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception sequencer: USER/FLUSH/KERNEL FSM, flush counter and PC redirect.
// Optional macro CP0_EXT_IRQ_EN adds a synchronized external interrupt input
// that takes exception entry with cause C_IRQ from USER mode when IE=1.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CP0_EXT_IRQ_EN
  input  logic        irq,
`endif
  input  logic        exc_req,
  input  logic [2:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        stall,
  input  logic        eret,
  input  logic        c0_we,
  input  logic [4:0]  c0_waddr,
  input  logic [31:0] c0_wdata,
  input  logic [4:0]  c0_raddr,
  output logic [31:0] c0_rdata,
  output logic        kernel_mode,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_r, state_nx_s;
  logic [2:0]  cnt_r, cnt_nx_s;
  logic        kernel_r, kernel_nx_s;
  logic        flush_r, flush_nx_s;
  logic        redirect_r, redirect_nx_s;
  logic [31:0] rpc_r, rpc_nx_s;
  logic        busy_r;

  logic        entry_s;
  logic [2:0]  entry_code_s;
  logic        ret_s;
  logic        sw_we_s;
  logic        dbl_s;
  logic [31:0] epc_s;
  logic        ie_s;

`ifdef CP0_EXT_IRQ_EN
  logic [1:0]  irq_sync_r;
  logic        irq_take_s;

  // Two-flop synchronizer for the asynchronous interrupt line.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_sync_r <= 2'b00;
    end else begin
      irq_sync_r <= {irq_sync_r[0], irq};
    end
  end

  assign irq_take_s   = (state_r == USER) && ie_s && !stall && !exc_req && irq_sync_r[1];
  assign entry_s      = (!stall && exc_req && (state_r != FLUSH)) || irq_take_s;
  assign entry_code_s = exc_req ? exc_cause : C_IRQ;
`else
  logic unused_ie_s;
  assign unused_ie_s  = ie_s;
  assign entry_s      = !stall && exc_req && (state_r != FLUSH);
  assign entry_code_s = exc_cause;
`endif

  // Exception beats eret and software writes; FLUSH ignores all requests.
  assign ret_s   = !stall && eret && !exc_req && (state_r == KERNEL);
  assign sw_we_s = !stall && c0_we && !exc_req && (state_r == KERNEL);
  assign dbl_s   = (state_r == KERNEL);

  cp0_regs u_regs (
    .clk         (clk),
    .reset       (reset),
    .kernel_mode (kernel_r),
    .hw_entry    (entry_s),
    .hw_dbl      (dbl_s),
    .hw_code     (entry_code_s),
    .hw_pc       (exc_pc),
    .hw_ret      (ret_s),
    .sw_we       (sw_we_s),
    .waddr       (c0_waddr),
    .wdata       (c0_wdata),
    .raddr       (c0_raddr),
    .rdata       (c0_rdata),
    .epc         (epc_s),
    .ie          (ie_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= USER;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      USER: begin
        if (entry_s) state_nx_s = FLUSH;
        else         state_nx_s = USER;
      end
      FLUSH: begin
        if (cnt_r == 3'd0) state_nx_s = KERNEL;
        else               state_nx_s = FLUSH;
      end
      KERNEL: begin
        if (entry_s)    state_nx_s = FLUSH;
        else if (ret_s) state_nx_s = USER;
        else            state_nx_s = KERNEL;
      end
      default: state_nx_s = USER;
    endcase
  end

  // Next values of the registered outputs and the flush down-counter.
  always_comb begin
    kernel_nx_s   = kernel_r;
    flush_nx_s    = 1'b0;
    redirect_nx_s = 1'b0;
    rpc_nx_s      = rpc_r;
    cnt_nx_s      = cnt_r;
    if (entry_s) begin
      kernel_nx_s   = 1'b1;
      flush_nx_s    = 1'b1;
      redirect_nx_s = 1'b1;
      rpc_nx_s      = VECTOR_ADDR;
      cnt_nx_s      = FLUSH_LOAD;
    end else if (ret_s) begin
      kernel_nx_s   = 1'b0;
      flush_nx_s    = 1'b1;
      redirect_nx_s = 1'b1;
      rpc_nx_s      = epc_s;
    end else if ((state_r == FLUSH) && (cnt_r != 3'd0)) begin
      flush_nx_s = 1'b1;
      cnt_nx_s   = cnt_r - 3'd1;
    end else begin
      flush_nx_s = 1'b0;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= 3'd0;
      kernel_r   <= 1'b0;
      flush_r    <= 1'b0;
      redirect_r <= 1'b0;
      rpc_r      <= 32'd0;
      busy_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_nx_s;
      kernel_r   <= kernel_nx_s;
      flush_r    <= flush_nx_s;
      redirect_r <= redirect_nx_s;
      rpc_r      <= rpc_nx_s;
      busy_r     <= (state_nx_s == FLUSH);
    end
  end

  assign kernel_mode = kernel_r;
  assign flush       = flush_r;
  assign redirect    = redirect_r;
  assign redirect_pc = rpc_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed vector table plus random
// stimulus against a behavioural model of the exception sequencer.
module tb_cp0_exc_ctrl;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req;
  logic [2:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        stall;
  logic        eret;
  logic        c0_we;
  logic [4:0]  c0_waddr;
  logic [31:0] c0_wdata;
  logic [4:0]  c0_raddr;
  logic [31:0] c0_rdata;
  logic        kernel_mode;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.VECTOR_ADDR(32'h0000_0080), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef CP0_EXT_IRQ_EN
    .irq         (1'b0),
`endif
    .exc_req     (exc_req),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc),
    .stall       (stall),
    .eret        (eret),
    .c0_we       (c0_we),
    .c0_waddr    (c0_waddr),
    .c0_wdata    (c0_wdata),
    .c0_raddr    (c0_raddr),
    .c0_rdata    (c0_rdata),
    .kernel_mode (kernel_mode),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy)
  );

  typedef struct {
    logic        rst;
    logic        exc;
    logic [2:0]  cause;
    logic [31:0] pc;
    logic        stl;
    logic        er;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic        k;
    logic        f;
    logic        r;
    logic [31:0] rpc;
    logic        b;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic exc, logic [2:0] cause, logic [31:0] pc,
                              logic stl, logic er, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] ra, logic k, logic f, logic r, logic [31:0] rpc,
                              logic b, logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.exc = exc; v.cause = cause; v.pc = pc; v.stl = stl; v.er = er;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.k = k; v.f = f; v.r = r;
    v.rpc = rpc; v.b = b; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: mode 0=user 1=flushing 2=kernel; fl = flush cycles still to show.
  int          m_mode, m_fl;
  logic        m_k, m_ie, m_dbl, m_red;
  logic [2:0]  m_code;
  logic [31:0] m_epc, m_rpc;

  task automatic model_step();
    int old;
    if (reset) begin
      m_mode = 0; m_fl = 0; m_k = 1'b0; m_ie = 1'b1; m_dbl = 1'b0;
      m_code = 3'd0; m_epc = 32'd0; m_red = 1'b0; m_rpc = 32'd0;
    end else begin
      old = m_mode;
      m_red = 1'b0;
      if (m_fl > 0) m_fl--;
      if (old == 1 && m_fl == 0) m_mode = 2;
      if (old != 1 && !stall) begin
        if (exc_req) begin
          if (old == 0) begin
            m_epc = exc_pc;
            m_dbl = 1'b0;
          end else begin
            m_dbl = 1'b1;
          end
          m_code = exc_cause; m_mode = 1; m_fl = FLUSH_CYCLES;
          m_k = 1'b1; m_red = 1'b1; m_rpc = 32'h80;
        end else begin
          if (old == 2 && eret) begin
            m_red = 1'b1; m_rpc = m_epc; m_k = 1'b0; m_mode = 0; m_fl = 1; m_dbl = 1'b0;
          end
          if (old == 2 && c0_we) begin
            case (c0_waddr)
              5'd12: m_ie = c0_wdata[1];
              5'd13: begin m_code = c0_wdata[4:2]; m_dbl = c0_wdata[31]; end
              5'd14: m_epc = c0_wdata;
              default: ;
            endcase
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] model_read(logic [4:0] a);
    case (a)
      5'd12:   return {30'd0, m_ie, m_k};
      5'd13:   return {m_dbl, 26'd0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    // rst exc cause pc stl er we wa wd ra | k f r rpc b rd
    tbl.push_back(mk(1,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd12, 0,0,0,32'h0, 0,32'h2));
    tbl.push_back(mk(0,1,3'd1,32'h40, 0,0,0,5'd0, 32'h0,  5'd13, 1,1,1,32'h80,1,32'h4));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd14, 1,1,0,32'h0, 1,32'h40));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd12, 1,0,0,32'h0, 0,32'h3));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,1,0,5'd0, 32'h0,  5'd13, 0,1,1,32'h40,0,32'h4));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd14, 0,0,0,32'h0, 0,32'h40));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,1,5'd14,32'h55, 5'd14, 0,0,0,32'h0, 0,32'h40));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,1,0,5'd0, 32'h0,  5'd7,  0,0,0,32'h0, 0,32'h0));
    tbl.push_back(mk(0,1,3'd2,32'h200,1,0,0,5'd0, 32'h0,  5'd14, 0,0,0,32'h0, 0,32'h40));
    tbl.push_back(mk(0,1,3'd2,32'h200,1,0,0,5'd0, 32'h0,  5'd14, 0,0,0,32'h0, 0,32'h40));
    tbl.push_back(mk(0,1,3'd2,32'h200,1,0,0,5'd0, 32'h0,  5'd14, 0,0,0,32'h0, 0,32'h40));
    tbl.push_back(mk(0,1,3'd2,32'h200,0,0,0,5'd0, 32'h0,  5'd14, 1,1,1,32'h80,1,32'h200));
    tbl.push_back(mk(0,1,3'd3,32'h300,0,0,0,5'd0, 32'h0,  5'd13, 1,1,0,32'h0, 1,32'h8));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,1,5'd14,32'h999,5'd14, 1,0,0,32'h0, 0,32'h200));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,1,5'd14,32'h40, 5'd14, 1,0,0,32'h0, 0,32'h40));
    tbl.push_back(mk(0,1,3'd3,32'h500,0,1,1,5'd14,32'h100,5'd13, 1,1,1,32'h80,1,32'h8000_000C));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd14, 1,1,0,32'h0, 1,32'h40));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd12, 1,0,0,32'h0, 0,32'h3));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,1,1,5'd14,32'h600,5'd14, 0,1,1,32'h40,0,32'h600));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd13, 0,0,0,32'h0, 0,32'hC));
    tbl.push_back(mk(0,1,3'd1,32'h44, 0,0,0,5'd0, 32'h0,  5'd12, 1,1,1,32'h80,1,32'h3));
    tbl.push_back(mk(1,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd12, 0,0,0,32'h0, 0,32'h2));
    tbl.push_back(mk(0,0,3'd0,32'h0,  0,0,0,5'd0, 32'h0,  5'd14, 0,0,0,32'h0, 0,32'h0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; exc_req = tbl[i].exc; exc_cause = tbl[i].cause; exc_pc = tbl[i].pc;
      stall = tbl[i].stl; eret = tbl[i].er; c0_we = tbl[i].we; c0_waddr = tbl[i].wa;
      c0_wdata = tbl[i].wd; c0_raddr = tbl[i].ra;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d kernel_mode", i), {31'd0, kernel_mode}, {31'd0, tbl[i].k});
      chk($sformatf("v%0d flush", i), {31'd0, flush}, {31'd0, tbl[i].f});
      chk($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, tbl[i].r});
      chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].b});
      chk($sformatf("v%0d c0_rdata", i), c0_rdata, tbl[i].rd);
      if (tbl[i].r || tbl[i].rst) chk($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].rpc);
    end

    // Random phase against the model; the first cycle resets both sides.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] addrs [4];
      addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'($urandom_range(0, 31));
      reset     = (n == 0) || ($urandom_range(0, 99) == 0);
      exc_req   = ($urandom_range(0, 9) == 0);
      exc_cause = 3'($urandom_range(1, 7));
      exc_pc    = $urandom & 32'hFFFF_FFFC;
      stall     = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      c0_we     = ($urandom_range(0, 3) == 0);
      c0_waddr  = addrs[$urandom_range(0, 3)];
      c0_wdata  = $urandom;
      c0_raddr  = addrs[$urandom_range(0, 3)];
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd%0d kernel_mode", n), {31'd0, kernel_mode}, {31'd0, m_k});
      chk($sformatf("rnd%0d flush", n), {31'd0, flush}, {31'd0, 1'(m_fl > 0)});
      chk($sformatf("rnd%0d redirect", n), {31'd0, redirect}, {31'd0, m_red});
      chk($sformatf("rnd%0d busy", n), {31'd0, busy}, {31'd0, 1'(m_mode == 1)});
      chk($sformatf("rnd%0d c0_rdata", n), c0_rdata, model_read(c0_raddr));
      if (m_red || reset) chk($sformatf("rnd%0d redirect_pc", n), redirect_pc, m_rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
